fifo_wr_arbiter: RTL

//   Round-robin write-port arbiter that shares one fifo write port (data_in/write_enable/full)

---
 rtl/fifo_wr_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between NUM_REQ valid/ready producers.
// Optional saturating beat/stall counters are enabled with `define FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_write_enable,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
 ,output logic [15:0]                   stat_beats,
  output logic [15:0]                   stat_stalls
`endif
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state, state_nxt;
  logic [GW-1:0]           grant_q, grant_nxt;
  logic [GW-1:0]           last_q, last_nxt;
  logic [CW-1:0]           beat_q, beat_nxt;
  logic [GW-1:0]           winner, cand;
  logic                    found;
  logic                    g_valid;
  logic [DATA_WIDTH-1:0]   g_data;
  logic                    xfer;
  logic                    stall;

  // Scan starts just after the last winner, so the previous owner is lowest priority.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GW'(i)) begin
        g_valid = req_valid[i];
        g_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Handshake: a beat moves in the cycle where req_valid[g] and req_ready[g] are both high;
  // ready is only ever raised for the granted requester, and never while the fifo is full.
  assign xfer  = (state == GRANT) && g_valid && !fifo_full;
  assign stall = (state == GRANT) && g_valid && fifo_full;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[grant_q] = 1'b1;
  end

  assign fifo_write_enable = xfer;
  assign fifo_data_in      = xfer ? g_data : '0;
  assign grant_id          = grant_q;
  assign busy              = (state == GRANT);

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    last_nxt  = last_q;
    beat_nxt  = beat_q;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = winner;
          last_nxt  = winner;
          beat_nxt  = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!g_valid) begin
          state_nxt = IDLE;
          beat_nxt  = '0;
        end else if (xfer) begin
          if (beat_q == CW'(MAX_BURST - 1)) begin
            state_nxt = IDLE;
            beat_nxt  = '0;
          end else begin
            beat_nxt = beat_q + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      beat_q  <= '0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      last_q  <= last_nxt;
      beat_q  <= beat_nxt;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_beats  <= '0;
      stat_stalls <= '0;
    end else begin
      if (xfer && stat_beats != 16'hFFFF)   stat_beats  <= stat_beats + 16'd1;
      if (stall && stat_stalls != 16'hFFFF) stat_stalls <= stat_stalls + 16'd1;
    end
  end
`endif

endmodule
